// File: rtl/fifo_rd_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_pkg: shared types and helpers for the fifo_stream_reader block.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_FLUSH  = 2'd2
  } rd_state_e;

  localparam int C_STATS_W_DEFAULT = 32;

  // The packet-end flag sits directly above the payload in each FIFO word.
  function automatic int last_bit(input int data_width);
    return data_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_skid_reg.sv
// +----------------------------------------------------------------------------+
// | stream_skid_reg: two-entry main+skid output buffer with occupancy count.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_skid_reg #(
  parameter int WIDTH = 513
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_occ
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_xfer;

  assign w_xfer  = (r_occ != 2'd0) && i_ready;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_main;
  assign o_occ   = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= 2'd0;
    end else begin
      case ({i_push, w_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by r_occ alone.
  always_ff @(posedge clk) begin
    case (r_occ)
      2'd0: begin
        if (i_push) r_main <= i_data;
      end
      2'd1: begin
        if (i_push && w_xfer) r_main <= i_data;
        else if (i_push)      r_skid <= i_data;
      end
      2'd2: begin
        if (w_xfer) r_main <= r_skid;
      end
      default: begin
        r_main <= r_main;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// +----------------------------------------------------------------------------+
// | fifo_stream_reader: drains a fallthrough FIFO onto a valid/ready stream    |
// | with packet tracking and packet-granular flush. FIFO_RD_STATS_EN adds      |
// | packet/drop counters. Rev 1.0 - initial release                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 512
`ifdef FIFO_RD_STATS_EN
  ,
  parameter int STATS_W    = C_STATS_W_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   i_fifo_dout,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic                  o_m_tlast,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  input  logic                  i_flush,
  output logic                  o_flush_busy,
  output logic                  o_in_pkt
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STATS_W-1:0]    o_pkt_cnt,
  output logic [STATS_W-1:0]    o_drop_cnt
`endif
);

  localparam int C_LAST = last_bit(DATA_WIDTH);

  rd_state_e         r_state;
  logic              r_flush_pending;
  logic [1:0]        w_occ;
  logic              w_rd_req;
  logic              w_pop;
  logic              w_push;
  logic              w_last_in;
  logic [DATA_WIDTH:0] w_head;

  assign w_last_in = i_fifo_dout[C_LAST];

  // A pending flush in IDLE blocks the pop so the next packet is caught whole.
  always_comb begin
    w_rd_req = 1'b0;
    case (r_state)
      ST_IDLE:   w_rd_req = !i_fifo_empty && (w_occ != 2'd2) && !r_flush_pending;
      ST_IN_PKT: w_rd_req = !i_fifo_empty && (w_occ != 2'd2);
      ST_FLUSH:  w_rd_req = !i_fifo_empty;
      default:   w_rd_req = 1'b0;
    endcase
  end

  assign w_pop        = w_rd_req && rst_n;
  assign w_push       = w_pop && (r_state != ST_FLUSH);
  assign o_fifo_rd_en = w_pop;
  assign o_flush_busy = r_flush_pending || (r_state == ST_FLUSH);
  assign o_in_pkt     = (r_state == ST_IN_PKT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_flush_pending <= 1'b0;
    end else begin
      if (r_flush_pending) begin
        if ((r_state == ST_FLUSH) && w_pop && w_last_in) r_flush_pending <= 1'b0;
      end else if (i_flush) begin
        r_flush_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_flush_pending)         r_state <= ST_FLUSH;
          else if (w_pop && !w_last_in) r_state <= ST_IN_PKT;
        end
        ST_IN_PKT: begin
          if (w_pop && w_last_in) r_state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (w_pop && w_last_in) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stream_skid_reg #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (i_fifo_dout),
    .i_ready (i_m_tready),
    .o_data  (w_head),
    .o_valid (o_m_tvalid),
    .o_occ   (w_occ)
  );

  assign o_m_tdata = w_head[DATA_WIDTH-1:0];
  assign o_m_tlast = w_head[C_LAST];

`ifdef FIFO_RD_STATS_EN
  logic [STATS_W-1:0] r_pkt_cnt;
  logic [STATS_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (o_m_tvalid && i_m_tready && o_m_tlast) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if ((r_state == ST_FLUSH) && w_pop && w_last_in) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_stream_reader: self-checking bench for fifo_stream_reader.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW:0]   i_fifo_dout;
  logic          i_fifo_empty;
  logic          o_fifo_rd_en;
  logic [DW-1:0] o_m_tdata;
  logic          o_m_tlast;
  logic          o_m_tvalid;
  logic          i_m_tready;
  logic          i_flush;
  logic          o_flush_busy;
  logic          o_in_pkt;
`ifdef FIFO_RD_STATS_EN
  logic [SW-1:0] o_pkt_cnt;
  logic [SW-1:0] o_drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  bit rand_ready = 1'b0;

  logic [DW:0] fq[$];
  logic [DW:0] obs[$];
  logic [DW:0] exp_q[$];

  fifo_stream_reader #(
    .DATA_WIDTH (DW)
`ifdef FIFO_RD_STATS_EN
    ,
    .STATS_W    (SW)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fifo_dout  (i_fifo_dout),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_m_tdata    (o_m_tdata),
    .o_m_tlast    (o_m_tlast),
    .o_m_tvalid   (o_m_tvalid),
    .i_m_tready   (i_m_tready),
    .i_flush      (i_flush),
    .o_flush_busy (o_flush_busy),
    .o_in_pkt     (o_in_pkt)
`ifdef FIFO_RD_STATS_EN
    ,
    .o_pkt_cnt    (o_pkt_cnt),
    .o_drop_cnt   (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW:0] mk(input bit last, input logic [DW-1:0] d);
    return {last, d};
  endfunction

  function void drive_fifo();
    i_fifo_empty = (fq.size() == 0);
    i_fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  // Fallthrough FIFO model plus output collector.
  always @(posedge clk) begin
    logic        p;
    logic        x;
    logic [DW:0] w;
    p = rst_n && o_fifo_rd_en;
    x = rst_n && o_m_tvalid && i_m_tready;
    w = {o_m_tlast, o_m_tdata};
    #1;
    if (p && fq.size() > 0) begin
      fq.delete(0);
      pop_cnt++;
    end
    if (x) obs.push_back(w);
    drive_fifo();
  end

  always @(negedge clk) begin
    if (rand_ready) i_m_tready = 1'($urandom_range(0, 1));
  end

  task automatic wait_drain(input int budget, output bit timed_out);
    int n = 0;
    timed_out = 1'b0;
    while (!(fq.size() == 0 && !o_m_tvalid && !o_flush_busy)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_m_tready = 1'b1; i_flush = 1'b0;
    fq.push_back(mk(1'b0, 16'h1111));
    drive_fifo();
    repeat (3) @(negedge clk);
    n_checks++; if (o_m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", o_m_tvalid); else n_pass++;
    n_checks++; if (o_fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", o_fifo_rd_en); else n_pass++;
    n_checks++; if (o_flush_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_flush_busy); else n_pass++;
    n_checks++; if (o_in_pkt !== 1'b0) $display("FAIL reset_in_pkt got %b want 0", o_in_pkt); else n_pass++;
    fq.delete(); drive_fifo();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_packet();
    logic [DW:0] a[3];
    bit       e_rd[5] = '{1, 1, 1, 0, 0};
    bit       e_v[5]  = '{0, 1, 1, 1, 0};
    bit       e_ip[5] = '{0, 1, 1, 0, 0};
    a[0] = mk(1'b0, 16'hA000); a[1] = mk(1'b0, 16'hA001); a[2] = mk(1'b1, 16'hA002);
    obs.delete(); i_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) fq.push_back(a[i]);
    drive_fifo();
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++; if (o_fifo_rd_en !== e_rd[c]) $display("FAIL basic_rd_en c%0d got %b want %b", c, o_fifo_rd_en, e_rd[c]); else n_pass++;
      n_checks++; if (o_m_tvalid !== e_v[c]) $display("FAIL basic_tvalid c%0d got %b want %b", c, o_m_tvalid, e_v[c]); else n_pass++;
      n_checks++; if (o_in_pkt !== e_ip[c]) $display("FAIL basic_in_pkt c%0d got %b want %b", c, o_in_pkt, e_ip[c]); else n_pass++;
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if ({o_m_tlast, o_m_tdata} !== a[c-1]) $display("FAIL basic_word c%0d got %h want %h", c, {o_m_tlast, o_m_tdata}, a[c-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW:0] a[3];
    bit to;
    int p0;
    a[0] = mk(1'b0, 16'hB0B0); a[1] = mk(1'b0, 16'hB1B1); a[2] = mk(1'b1, 16'hB2B2);
    obs.delete(); i_m_tready = 1'b0; p0 = pop_cnt;
    for (int i = 0; i < 3; i++) fq.push_back(a[i]);
    drive_fifo();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (!o_m_tvalid || {o_m_tlast, o_m_tdata} !== a[0]) $display("FAIL bp_hold c%0d got v=%b %h want v=1 %h", c, o_m_tvalid, {o_m_tlast, o_m_tdata}, a[0]);
      else n_pass++;
    end
    n_checks++; if (pop_cnt - p0 !== 2) $display("FAIL bp_pops got %0d want 2", pop_cnt - p0); else n_pass++;
    n_checks++; if (o_fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en got %b want 0", o_fifo_rd_en); else n_pass++;
    i_m_tready = 1'b1;
    wait_drain(50, to);
    n_checks++; if (to) $display("FAIL bp_drain timeout got 1 want 0"); else n_pass++;
    n_checks++; if (obs.size() !== 3) $display("FAIL bp_count got %0d want 3", obs.size()); else n_pass++;
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== a[i]) $display("FAIL bp_order i%0d got %h want %h", i, obs[i], a[i]); else n_pass++;
    end
  endtask

  task automatic test_flush_idle();
    bit to;
    int p0;
    obs.delete(); i_m_tready = 1'b1; p0 = pop_cnt;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    fq.push_back(mk(1'b0, 16'hBB00)); fq.push_back(mk(1'b1, 16'hBB01)); fq.push_back(mk(1'b1, 16'hCC00));
    drive_fifo();
    n_checks++; if (o_flush_busy !== 1'b1) $display("FAIL fidle_busy_set got %b want 1", o_flush_busy); else n_pass++;
    for (int n = 0; n < 20 && (pop_cnt - p0) < 2; n++) @(negedge clk);
    n_checks++; if (pop_cnt - p0 !== 2) $display("FAIL fidle_pops got %0d want 2", pop_cnt - p0); else n_pass++;
    n_checks++; if (o_flush_busy !== 1'b0) $display("FAIL fidle_busy_clr got %b want 0", o_flush_busy); else n_pass++;
    wait_drain(50, to);
    n_checks++; if (to) $display("FAIL fidle_drain timeout got 1 want 0"); else n_pass++;
    n_checks++;
    if (obs.size() !== 1 || obs[0] !== mk(1'b1, 16'hCC00)) $display("FAIL fidle_out got n=%0d w=%h want n=1 w=%h", obs.size(), (obs.size() != 0) ? obs[0] : '0, mk(1'b1, 16'hCC00));
    else n_pass++;
  endtask

  task automatic test_flush_in_pkt();
    bit to;
    obs.delete(); i_m_tready = 1'b1;
    fq.push_back(mk(1'b0, 16'hD000)); drive_fifo();
    for (int n = 0; n < 20 && !o_in_pkt; n++) @(negedge clk);
    n_checks++; if (o_in_pkt !== 1'b1) $display("FAIL fpkt_in_pkt got %b want 1", o_in_pkt); else n_pass++;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    fq.push_back(mk(1'b1, 16'hD001)); fq.push_back(mk(1'b1, 16'hE000)); drive_fifo();
    wait_drain(50, to);
    n_checks++; if (to) $display("FAIL fpkt_drain timeout got 1 want 0"); else n_pass++;
    n_checks++;
    if (obs.size() !== 2 || obs[0] !== mk(1'b0, 16'hD000) || obs[1] !== mk(1'b1, 16'hD001))
      $display("FAIL fpkt_out got n=%0d want D000,D001 only", obs.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    obs.delete(); i_m_tready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(mk(1'b0, 16'hF000 + 16'(i)));
    drive_fifo();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (o_m_tvalid !== 1'b1 || o_flush_busy !== 1'b1 || o_in_pkt !== 1'b1) $display("FAIL rmid_pre got v=%b b=%b p=%b want 1 1 1", o_m_tvalid, o_flush_busy, o_in_pkt); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_m_tvalid !== 1'b0) $display("FAIL rmid_tvalid got %b want 0", o_m_tvalid); else n_pass++;
    n_checks++; if (o_fifo_rd_en !== 1'b0) $display("FAIL rmid_rd_en got %b want 0", o_fifo_rd_en); else n_pass++;
    n_checks++; if (o_flush_busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", o_flush_busy); else n_pass++;
    n_checks++; if (o_in_pkt !== 1'b0) $display("FAIL rmid_in_pkt got %b want 0", o_in_pkt); else n_pass++;
    fq.delete(); drive_fifo();
    repeat (2) @(negedge clk);
    obs.delete();
    rst_n = 1'b1; i_m_tready = 1'b1;
    fq.push_back(mk(1'b1, 16'h6060)); drive_fifo();
    wait_drain(50, to);
    n_checks++; if (to) $display("FAIL rmid_drain timeout got 1 want 0"); else n_pass++;
    n_checks++;
    if (obs.size() !== 1 || obs[0] !== mk(1'b1, 16'h6060)) $display("FAIL rmid_resume got n=%0d want 1 word 6060", obs.size());
    else n_pass++;
  endtask

  // Packet-level reference: a flushed packet vanishes, every other packet appears intact and in order.
  task automatic test_random();
    bit to;
    int len;
    bit drop;
    logic [DW:0] w;
    obs.delete(); exp_q.delete();
    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      drop = ($urandom_range(0, 3) == 0);
      len  = $urandom_range(1, 4);
      if (drop) begin
        wait_drain(200, to);
        n_checks++; if (to) $display("FAIL rand_predrain p%0d timeout got 1 want 0", p); else n_pass++;
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
      end
      for (int k = 0; k < len; k++) begin
        w = mk(k == len - 1, 16'($urandom));
        fq.push_back(w);
        if (!drop) exp_q.push_back(w);
      end
      drive_fifo();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(1000, to);
    rand_ready = 1'b0;
    i_m_tready = 1'b1;
    n_checks++; if (to) $display("FAIL rand_drain timeout got 1 want 0"); else n_pass++;
    n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL rand_word i%0d got %h want %h", i, obs[i], exp_q[i]); else n_pass++;
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    bit to;
    @(negedge clk);
    rst_n = 1'b0; fq.delete(); drive_fifo();
    @(negedge clk);
    rst_n = 1'b1; i_m_tready = 1'b1; obs.delete();
    n_checks++; if (o_pkt_cnt !== '0 || o_drop_cnt !== '0) $display("FAIL stats_reset got %0d %0d want 0 0", o_pkt_cnt, o_drop_cnt); else n_pass++;
    for (int i = 0; i < 17; i++) fq.push_back(mk(1'b1, 16'(i)));
    drive_fifo();
    wait_drain(200, to);
    n_checks++; if (to) $display("FAIL stats_drain timeout got 1 want 0"); else n_pass++;
    n_checks++; if (o_pkt_cnt !== 4'd1) $display("FAIL stats_pkt_wrap got %0d want 1", o_pkt_cnt); else n_pass++;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    fq.push_back(mk(1'b0, 16'h0A0A)); fq.push_back(mk(1'b1, 16'h0B0B)); drive_fifo();
    wait_drain(100, to);
    n_checks++; if (o_drop_cnt !== 4'd1) $display("FAIL stats_drop got %0d want 1", o_drop_cnt); else n_pass++;
    n_checks++; if (o_pkt_cnt !== 4'd1) $display("FAIL stats_pkt_after_drop got %0d want 1", o_pkt_cnt); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_m_tready = 1'b1; i_flush = 1'b0;
    drive_fifo();
    @(negedge clk);
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_flush_idle();
    test_flush_in_pkt();
    test_reset_mid();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains a fallthrough FIFO (head word valid whenever empty=0; rd_en pops the head and the next word appears the following cycle) onto a valid/ready output stream.
- Each FIFO word is {last, data}: bit DATA_WIDTH marks the final word of a packet.
- Adds packet-boundary tracking and a packet-granular flush.
- Sits between the parser-side FIFO and downstream match/action stages.

Parameters:
- DATA_WIDTH, 512, payload width; FIFO word width is DATA_WIDTH+1.
- STATS_W, 32, counter width, used only with the optional feature.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo_dout  input  DATA_WIDTH+1  head word of FIFO; bit DATA_WIDTH = last.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop FIFO head this cycle.
- m_tdata  output  DATA_WIDTH  output payload.
- m_tlast  output  1  final word of packet.
- m_tvalid  output  1  output word valid.
- m_tready  input  1  downstream accepts.
- flush  input  1  single-cycle request to discard the next whole packet.
- flush_busy  output  1  flush pending or in progress.
- in_pkt  output  1  a packet has been started on m_* and its last word is not yet popped.

Behaviour:
- Reset (reset=0, asynchronous): occupancy=0, state=IDLE, flush_pending=0, m_tvalid=0, fifo_rd_en=0, flush_busy=0, in_pkt=0. Data registers are not reset.
- Output buffer: 2-entry skid register (main + skid) with occupancy 0..2. m_tvalid = (occ!=0). Presents the main entry; the skid entry shifts into main on transfer.
- fifo_rd_en in IDLE/IN_PKT = !fifo_empty && occ<2 && reset. No combinational path from m_tready to fifo_rd_en.
- Latency: word popped at cycle N is on m_* at N+1 when occ was 0.
- Sustained throughput is 1 word/clk with m_tready held high.
- Simultaneous pop and transfer leaves occ unchanged.
- Word order is strictly preserved.
- m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0.
- FSM states:
  - IDLE: at a packet boundary. Popping a word with last=0 goes to IN_PKT; popping a word with last=1 stays in IDLE (single-word packet).
  - IN_PKT: popping a word with last=1 goes to IDLE.
  - FLUSH: fifo_rd_en = !fifo_empty (ignores occ). Popped words are discarded and never enter the buffer. Popping a word with last=1 goes to IDLE and clears flush_pending.
- flush handling:
  - Sets flush_pending. Further flush pulses while pending are ignored, so one packet is dropped per accepted request.
  - Transition to FLUSH happens only from IDLE, on the cycle after flush_pending is seen, before the next pop.
  - A flush raised during IN_PKT waits for that packet's last word. Partial packets are never emitted.
  - flush and a pop in the same IDLE cycle: the popped word is delivered; flush applies to the following packet.
  - Words already in the skid buffer are always delivered, never flushed.
- flush_busy = flush_pending || state==FLUSH.
- in_pkt = (state==IN_PKT).
- FIFO empty: no pop; state is held. FLUSH waits indefinitely for a last word.
- Reset mid-packet: all state is cleared. Any FIFO content is the FIFO's own concern; it is reset by the same domain.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- Defined: adds outputs pkt_cnt [STATS_W-1:0] and drop_cnt [STATS_W-1:0].
  - pkt_cnt increments when m_tvalid && m_tready && m_tlast.
  - drop_cnt increments on each popped last word while in FLUSH.
  - Both wrap modulo 2^STATS_W and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rd_pkg: state enum {IDLE, IN_PKT, FLUSH} (2-bit); LAST_BIT index helper; default STATS_W.
- One natural sub-module, stream_skid_reg: the 2-entry buffer with push/pop, occ, data+last storage.
- The FSM, flush logic and stats stay in the top module.

Test Plan:
- Three-word packet A0,A1,A2(last) in FIFO, m_tready=1 -> fifo_rd_en high for 3 consecutive cycles; m_* shows A0..A2 on consecutive cycles starting one cycle after the first pop; m_tlast only with A2; in_pkt high after the A0 pop, low after the A2 pop.
- Same stream with m_tready=0 for 4 cycles -> exactly 2 pops then fifo_rd_en=0; A0 held stable; on release, A0,A1,A2 delivered in order with no loss or duplication.
- flush pulse in IDLE, FIFO holds B0,B1(last),C0(last) -> B0,B1 popped and discarded (not on m_*); flush_busy drops after the B1 pop; C0 delivered with m_tlast=1; drop_cnt=1 if stats enabled.
- flush pulse while in IN_PKT after D0 popped, FIFO D1(last),E0(last) -> D1 delivered, E0 discarded, no partial packet emitted.
- reset=0 asserted mid-packet with occ=2 -> m_tvalid, fifo_rd_en and flush_busy go 0 immediately (asynchronously); after release, operation resumes from IDLE with a new packet.
- Stats with STATS_W=4: 17 single-word packets -> pkt_cnt reads 1 (wrap).
